// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter sequencing controller.
package counter_sched_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_REPEAT_W = 4;
  localparam int unsigned STATE_W      = 3;
  localparam int unsigned OP_W         = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_START  = 2'd0,
    OP_STOP   = 2'd1,
    OP_PAUSE  = 2'd2,
    OP_RESUME = 2'd3
  } cmd_op_e;

  // Legal op/state pairs; everything else is accepted but flagged as an error.
  function automatic logic cmd_is_legal(input cmd_op_e op, input state_e st);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_START:  ok = (st == ST_IDLE) || (st == ST_DONE) || (st == ST_PAUSED);
      OP_STOP:   ok = (st == ST_RUN) || (st == ST_PAUSED) || (st == ST_DONE);
      OP_PAUSE:  ok = (st == ST_RUN);
      OP_RESUME: ok = (st == ST_PAUSED);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/counter_sched_ctrl_ctr.sv
// Loadable up-counter datapath with load > rst > ena priority (all synchronous).
module counter_sched_ctrl_ctr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (rst) begin
      count_d = '0;
    end else if (ena) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_sched_ctrl.sv
// Command-driven sequencer for the loadable counter: one-shot / auto-reload
// periodic ticks with a repeat limit, pause/resume and stop.
module counter_sched_ctrl
  import counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned REPEAT_W = DEF_REPEAT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [WIDTH-1:0]    cfg_start,
  input  logic [WIDTH-1:0]    cfg_terminal,
  input  logic                cfg_autoreload,
  input  logic [REPEAT_W-1:0] cfg_repeat,
  input  logic                hold_i,
  output logic [WIDTH-1:0]    count_o,
  output logic                tick_o,
  output logic                done_o,
  output logic                err_o,
  output logic                busy_o,
  output logic [REPEAT_W-1:0] remaining_o,
  output logic [STATE_W-1:0]  state_o
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     start_q, start_d;
  logic [WIDTH-1:0]     terminal_q, terminal_d;
  logic                 autoreload_q, autoreload_d;
  logic [REPEAT_W-1:0]  remaining_q, remaining_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic                 ctr_load_c;
  logic                 ctr_rst_c;
  logic                 ctr_ena_c;
  logic [WIDTH-1:0]     count_c;

  cmd_op_e              op_c;
  logic                 cmd_fire_c;
  logic                 cmd_legal_c;
  logic                 cmd_ok_c;
  logic                 term_evt_c;
  logic                 reload_c;

  assign op_c        = cmd_op_e'(cmd_op);
  assign cmd_fire_c  = cmd_valid && ready_q;
  assign cmd_legal_c = cmd_is_legal(op_c, state_q);
  assign cmd_ok_c    = cmd_fire_c && cmd_legal_c;

  // An accepted command in the same cycle wins over a terminal event.
  assign term_evt_c = (state_q == ST_RUN) && (count_c == terminal_q) && !hold_i && !cmd_fire_c;
  assign reload_c   = autoreload_q && ((remaining_q == '0) || (remaining_q > REPEAT_W'(1)));

  counter_sched_ctrl_ctr #(
    .WIDTH (WIDTH)
  ) u_ctr (
    .clk        (clk),
    .load       (ctr_load_c),
    .rst        (ctr_rst_c),
    .ena        (ctr_ena_c),
    .load_value (start_q),
    .count_o    (count_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_q      <= '0;
      terminal_q   <= '0;
      autoreload_q <= 1'b0;
      remaining_q  <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      terminal_q   <= terminal_d;
      autoreload_q <= autoreload_d;
      remaining_q  <= remaining_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (cmd_ok_c) begin
      case (op_c)
        OP_START:  state_d = ST_LOAD;
        OP_STOP:   state_d = ST_IDLE;
        OP_PAUSE:  state_d = ST_PAUSED;
        OP_RESUME: state_d = ST_RUN;
        default:   state_d = state_q;
      endcase
    end else if (state_q == ST_LOAD) begin
      state_d = ST_RUN;
    end else if (term_evt_c && !reload_c) begin
      state_d = ST_DONE;
    end
  end

  // Counter control, config latches, repeat counter and pulse outputs.
  always_comb begin
    ctr_load_c   = 1'b0;
    ctr_rst_c    = 1'b0;
    ctr_ena_c    = 1'b0;
    start_d      = start_q;
    terminal_d   = terminal_q;
    autoreload_d = autoreload_q;
    remaining_d  = remaining_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = cmd_fire_c && !cmd_legal_c;
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_PAUSED);
    ready_d      = (state_d != ST_LOAD);

    if (cmd_ok_c) begin
      case (op_c)
        OP_START: begin
          start_d      = cfg_start;
          terminal_d   = cfg_terminal;
          autoreload_d = cfg_autoreload;
          remaining_d  = cfg_repeat;
        end
        OP_STOP: begin
          ctr_rst_c   = 1'b1;
          remaining_d = '0;
        end
        default: begin
          ctr_ena_c = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        ST_LOAD: ctr_load_c = 1'b1;
        ST_RUN: begin
          if (term_evt_c) begin
            tick_d = 1'b1;
            if (reload_c) begin
              ctr_load_c = 1'b1;
              if (remaining_q != '0) begin
                remaining_d = remaining_q - REPEAT_W'(1);
              end
            end else begin
              done_d      = 1'b1;
              remaining_d = '0;
            end
          end else begin
            ctr_ena_c = !hold_i;
          end
        end
        default: ctr_ena_c = 1'b0;
      endcase
    end

    // Global reset clears the datapath through its rst pin only.
    if (rst) begin
      ctr_load_c = 1'b0;
      ctr_ena_c  = 1'b0;
      ctr_rst_c  = 1'b1;
    end
  end

  assign cmd_ready   = ready_q;
  assign count_o     = count_c;
  assign tick_o      = tick_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign remaining_o = remaining_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// Scoreboard bench for counter_sched_ctrl: pulse events are queued when
// stimulus is issued and checked by an independent negedge monitor.
module tb_counter_sched_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned RW = 4;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_STOP   = 2'd1;
  localparam logic [1:0] OP_PAUSE  = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;

  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_PAUSED = 3, S_DONE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [W-1:0]  cfg_start = '0;
  logic [W-1:0]  cfg_terminal = '0;
  logic          cfg_autoreload = 1'b0;
  logic [RW-1:0] cfg_repeat = '0;
  logic          hold_i = 1'b0;
  logic [W-1:0]  count_o;
  logic          tick_o;
  logic          done_o;
  logic          err_o;
  logic          busy_o;
  logic [RW-1:0] remaining_o;
  logic [2:0]    state_o;

  typedef struct packed {
    logic          tick;
    logic          done;
    logic          err;
    logic [W-1:0]  count;
    logic [2:0]    state;
    logic [RW-1:0] rem;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  counter_sched_ctrl #(.WIDTH(W), .REPEAT_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cfg_start      (cfg_start),
    .cfg_terminal   (cfg_terminal),
    .cfg_autoreload (cfg_autoreload),
    .cfg_repeat     (cfg_repeat),
    .hold_i         (hold_i),
    .count_o        (count_o),
    .tick_o         (tick_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .remaining_o    (remaining_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Monitor: every tick/done/err pulse must match the next queued expectation.
  always @(negedge clk) begin
    ev_t act;
    ev_t want;
    if (tick_o || done_o || err_o) begin
      act = {tick_o, done_o, err_o, count_o, state_o, remaining_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got t%0b d%0b e%0b cnt=%0d st=%0d rem=%0d, required no pulse",
                 act.tick, act.done, act.err, act.count, act.state, act.rem);
      end else begin
        want = exp_q.pop_front();
        if (act !== want) begin
          n_bad++;
          $display("FAIL pulse_event: got t%0b d%0b e%0b cnt=%0d st=%0d rem=%0d, required t%0b d%0b e%0b cnt=%0d st=%0d rem=%0d",
                   act.tick, act.done, act.err, act.count, act.state, act.rem,
                   want.tick, want.done, want.err, want.count, want.state, want.rem);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic t, input logic d, input logic e,
                      input logic [W-1:0] c, input logic [2:0] s, input logic [RW-1:0] r);
    ev_t ev;
    ev = {t, d, e, c, s, r};
    exp_q.push_back(ev);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] st, input logic [W-1:0] term,
                       input logic ar, input logic [RW-1:0] rep);
    cmd_valid      = 1'b1;
    cmd_op         = op;
    cfg_start      = st;
    cfg_terminal   = term;
    cfg_autoreload = ar;
    cfg_repeat     = rep;
    cyc();
    cmd_valid      = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_state", 32'(state_o), 32'(S_IDLE));
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rem", 32'(remaining_o), 32'd0);
    chk("rst_pulses", 32'({tick_o, done_o, err_o}), 32'd0);
    rst = 1'b0;

    // One-shot 3..6
    push(1'b1, 1'b1, 1'b0, 8'd6, 3'(S_DONE), 4'd0);
    issue(OP_START, 8'd3, 8'd6, 1'b0, 4'd0);
    chk("os_load_state", 32'(state_o), 32'(S_LOAD));
    chk("os_load_ready", 32'(cmd_ready), 32'd0);
    chk("os_load_busy", 32'(busy_o), 32'd1);
    cyc();
    chk("os_run_state", 32'(state_o), 32'(S_RUN));
    chk("os_count3", 32'(count_o), 32'd3);
    for (int i = 4; i <= 6; i++) begin
      cyc();
      chk("os_count", 32'(count_o), 32'(i));
    end
    cyc();
    chk("os_done_state", 32'(state_o), 32'(S_DONE));
    chk("os_done_tick", 32'(tick_o), 32'd1);
    cyc();
    chk("os_hold_count", 32'(count_o), 32'd6);
    chk("os_tick_single", 32'(tick_o), 32'd0);

    // Auto-reload 250..2 wrapping, 3 periods of 9 cycles
    push(1'b1, 1'b0, 1'b0, 8'd250, 3'(S_RUN), 4'd2);
    push(1'b1, 1'b0, 1'b0, 8'd250, 3'(S_RUN), 4'd1);
    push(1'b1, 1'b1, 1'b0, 8'd2, 3'(S_DONE), 4'd0);
    issue(OP_START, 8'd250, 8'd2, 1'b1, 4'd3);
    chk("ar_load_state", 32'(state_o), 32'(S_LOAD));
    chk("ar_rem3", 32'(remaining_o), 32'd3);
    cyc();
    chk("ar_count250", 32'(count_o), 32'd250);
    repeat (6) cyc();
    chk("ar_wrap0", 32'(count_o), 32'd0);
    repeat (2) cyc();
    chk("ar_term_count", 32'(count_o), 32'd2);
    chk("ar_no_early_tick", 32'(tick_o), 32'd0);
    cyc();
    chk("ar_p1_tick", 32'(tick_o), 32'd1);
    chk("ar_p1_rem", 32'(remaining_o), 32'd2);
    repeat (9) cyc();
    chk("ar_p2_tick", 32'(tick_o), 32'd1);
    chk("ar_p2_rem", 32'(remaining_o), 32'd1);
    repeat (9) cyc();
    chk("ar_p3_state", 32'(state_o), 32'(S_DONE));
    chk("ar_p3_count", 32'(count_o), 32'd2);
    chk("ar_p3_rem", 32'(remaining_o), 32'd0);

    // Infinite reload with start == terminal, hold for 4 cycles, then STOP
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 8'd5, 3'(S_RUN), 4'd0);
    issue(OP_START, 8'd5, 8'd5, 1'b1, 4'd0);
    chk("inf_load_state", 32'(state_o), 32'(S_LOAD));
    cyc();
    chk("inf_run_count", 32'(count_o), 32'd5);
    repeat (3) cyc();
    hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("inf_hold_count", 32'(count_o), 32'd5);
      chk("inf_hold_notick", 32'(tick_o), 32'd0);
    end
    hold_i = 1'b0;
    cyc();
    chk("inf_resume_tick", 32'(tick_o), 32'd1);
    issue(OP_STOP, 8'd0, 8'd0, 1'b0, 4'd0);
    chk("inf_stop_state", 32'(state_o), 32'(S_IDLE));
    chk("inf_stop_count", 32'(count_o), 32'd0);
    chk("inf_stop_notick", 32'(tick_o), 32'd0);
    chk("inf_stop_busy", 32'(busy_o), 32'd0);

    // PAUSE on the terminal cycle suppresses the event until after RESUME
    push(1'b1, 1'b1, 1'b0, 8'd12, 3'(S_DONE), 4'd0);
    issue(OP_START, 8'd10, 8'd12, 1'b0, 4'd0);
    repeat (3) cyc();
    chk("pc_at_term", 32'(count_o), 32'd12);
    issue(OP_PAUSE, 8'd0, 8'd0, 1'b0, 4'd0);
    chk("pc_paused", 32'(state_o), 32'(S_PAUSED));
    chk("pc_paused_count", 32'(count_o), 32'd12);
    chk("pc_no_tick", 32'(tick_o), 32'd0);
    cyc();
    chk("pc_still_paused", 32'(count_o), 32'd12);
    issue(OP_RESUME, 8'd0, 8'd0, 1'b0, 4'd0);
    chk("pc_resumed", 32'(state_o), 32'(S_RUN));
    chk("pc_resume_notick", 32'(tick_o), 32'd0);
    cyc();
    chk("pc_done", 32'(state_o), 32'(S_DONE));

    // Illegal commands and LOAD back-pressure
    issue(OP_STOP, 8'd0, 8'd0, 1'b0, 4'd0);
    chk("er_idle", 32'(state_o), 32'(S_IDLE));
    push(1'b0, 1'b0, 1'b1, 8'd0, 3'(S_IDLE), 4'd0);
    issue(OP_RESUME, 8'd0, 8'd0, 1'b0, 4'd0);
    chk("er_resume_err", 32'(err_o), 32'd1);
    chk("er_resume_state", 32'(state_o), 32'(S_IDLE));
    push(1'b0, 1'b0, 1'b1, 8'd0, 3'(S_IDLE), 4'd0);
    issue(OP_STOP, 8'd0, 8'd0, 1'b0, 4'd0);
    chk("er_stop_idle_err", 32'(err_o), 32'd1);
    cyc();
    chk("er_err_single", 32'(err_o), 32'd0);

    issue(OP_START, 8'h3E, 8'h80, 1'b1, 4'd5);
    cmd_valid = 1'b1;
    cmd_op    = OP_PAUSE;
    #1;
    chk("hs_load_ready", 32'(cmd_ready), 32'd0);
    cyc();
    chk("hs_not_taken", 32'(state_o), 32'(S_RUN));
    chk("hs_run_count", 32'(count_o), 32'h3E);
    chk("hs_ready_back", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    chk("hs_paused", 32'(state_o), 32'(S_PAUSED));
    chk("hs_paused_count", 32'(count_o), 32'h3E);
    issue(OP_RESUME, 8'd0, 8'd0, 1'b0, 4'd0);
    repeat (2) cyc();
    chk("mr_count40", 32'(count_o), 32'h40);
    chk("mr_rem5", 32'(remaining_o), 32'd5);

    // Reset mid-run
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_state", 32'(state_o), 32'(S_IDLE));
    chk("mr_count", 32'(count_o), 32'd0);
    chk("mr_rem", 32'(remaining_o), 32'd0);
    chk("mr_pulses", 32'({tick_o, done_o, err_o}), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_ready", 32'(cmd_ready), 32'd1);

    repeat (3) cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
